// File: rtl/mfp_uart_tx_fifo.sv
// UART transmit path: byte FIFO feeding a 16x-oversampled serializer.
// Ports:
//   HCLK, HRESETn      system clock, asynchronous active-low reset
//   baud_en            one-cycle strobe at 16x the baud rate
//   wr_en, wr_data     push a byte into the FIFO
//   fifo_clr           flush FIFO pointers, count and overrun
//   lcr[5:0]           word length, extra stop, parity enable/even/stick
//   break_en           force the serial line low
//   stx                serial output
//   fifo_count         FIFO occupancy (0..FIFO_DEPTH)
//   fifo_empty         FIFO holds no bytes
//   tx_empty           FIFO empty and serializer idle
//   overrun            sticky: a write was dropped because the FIFO was full
module mfp_uart_tx_fifo #(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  input  logic                        baud_en,
  input  logic                        wr_en,
  input  logic [7:0]                  wr_data,
  input  logic                        fifo_clr,
  input  logic [5:0]                  lcr,
  input  logic                        break_en,
  output logic                        stx,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        fifo_empty,
  output logic                        tx_empty,
  output logic                        overrun
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Parity of the transmitted bits only; bits above the word length are ignored.
  function automatic logic calc_parity(input logic [7:0] data, input logic [5:0] mode);
    logic [7:0] mask;
    logic       x;
    case (mode[1:0])
      2'd0:    mask = 8'h1F;
      2'd1:    mask = 8'h3F;
      2'd2:    mask = 8'h7F;
      default: mask = 8'hFF;
    endcase
    x = ^(data & mask);
    if (mode[5])      return ~mode[4];
    else if (mode[4]) return x;
    else              return ~x;
  endfunction

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overrun;

  state_t        r_state;
  logic [3:0]    r_tick;
  logic [2:0]    r_bit;
  logic          r_stop_ext;
  logic [7:0]    r_data;
  logic [3:0]    r_lcr;
  logic          r_par;
  logic          r_stx;

  logic          w_full;
  logic          w_empty;
  logic          w_bit_end;
  logic          w_stop_end;
  logic          w_pop;
  logic          w_push_req;
  logic          w_push;
  logic [2:0]    w_last_bit;
  logic [7:0]    w_head;

  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_head     = r_mem[r_rd_ptr];
  assign w_bit_end  = baud_en && (r_tick == 4'd15);
  assign w_last_bit = 3'd4 + {1'b0, r_lcr[1:0]};

  // Stop length: 16 ticks, or 32 (24 for 5-bit words) with the extra stop bit.
  // r_stop_ext marks that the first 16 ticks of the stop period have elapsed.
  always_comb begin
    w_stop_end = 1'b0;
    if (baud_en) begin
      if (!r_lcr[2])                w_stop_end = !r_stop_ext && (r_tick == 4'd15);
      else if (r_lcr[1:0] == 2'd0)  w_stop_end = r_stop_ext && (r_tick == 4'd7);
      else                          w_stop_end = r_stop_ext && (r_tick == 4'd15);
    end
  end

  // Pop when idle on a baud tick, or back-to-back at the end of a stop period.
  assign w_pop = !w_empty && ((r_state == S_IDLE && baud_en) ||
                              (r_state == S_STOP && w_stop_end));

  // A push while full is accepted only if a pop frees a slot in the same cycle.
  assign w_push_req = wr_en && !fifo_clr;
  assign w_push     = w_push_req && (!w_full || w_pop);

  // FIFO storage (no reset needed; validity is tracked by the pointers).
  always_ff @(posedge HCLK) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  // FIFO pointers, occupancy and overrun flag.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else if (fifo_clr) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push_req && w_full && !w_pop) r_overrun <= 1'b1;
    end
  end

  // Serializer FSM with registered line output.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state    <= S_IDLE;
      r_tick     <= 4'd0;
      r_bit      <= 3'd0;
      r_stop_ext <= 1'b0;
      r_data     <= 8'd0;
      r_lcr      <= 4'd0;
      r_par      <= 1'b0;
      r_stx      <= 1'b1;
    end else begin
      if (baud_en && r_state != S_IDLE) r_tick <= r_tick + 4'd1;
      if (w_pop) begin
        // Load next byte and freeze the line settings for the whole frame.
        r_state <= S_START;
        r_tick  <= 4'd0;
        r_data  <= w_head;
        r_lcr   <= lcr[3:0];
        r_par   <= calc_parity(w_head, lcr);
        r_stx   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: r_stx <= 1'b1;
          S_START: begin
            if (w_bit_end) begin
              r_state <= S_DATA;
              r_bit   <= 3'd0;
              r_stx   <= r_data[0];
            end
          end
          S_DATA: begin
            if (w_bit_end) begin
              if (r_bit == w_last_bit) begin
                if (r_lcr[3]) begin
                  r_state <= S_PARITY;
                  r_stx   <= r_par;
                end else begin
                  r_state    <= S_STOP;
                  r_stop_ext <= 1'b0;
                  r_stx      <= 1'b1;
                end
              end else begin
                r_bit <= r_bit + 3'd1;
                r_stx <= r_data[r_bit + 3'd1];
              end
            end
          end
          S_PARITY: begin
            if (w_bit_end) begin
              r_state    <= S_STOP;
              r_stop_ext <= 1'b0;
              r_stx      <= 1'b1;
            end
          end
          S_STOP: begin
            if (w_bit_end) r_stop_ext <= 1'b1;
            if (w_stop_end) begin
              r_state <= S_IDLE;
              r_tick  <= 4'd0;
              r_stx   <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Break overrides the registered line without stalling the serializer.
  assign stx        = r_stx & ~break_en;
  assign fifo_count = r_count;
  assign fifo_empty = w_empty;
  assign tx_empty   = w_empty && (r_state == S_IDLE);
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_mfp_uart_tx_fifo.sv
// Testbench for mfp_uart_tx_fifo: table of frame formats checked bit-cell by
// bit-cell against a scoreboard queue, plus sequences for FIFO overflow/clear,
// back-to-back frames, break and asynchronous reset.
module tb_mfp_uart_tx_fifo;

  localparam int unsigned DEPTH     = 16;
  localparam int          TICK_CLKS = 64;   // 16 baud ticks x 4 clocks

  typedef struct {
    logic [5:0] lcr;
    logic [7:0] data;
    logic [8:0] exp_bits;   // data bits (then parity) in transmit order, LSB first
    int         nbits;
    int         stop_ticks;
  } vec_t;

  typedef struct {
    logic lvl;
    int   len;
  } cell_t;

  logic       HCLK;
  logic       HRESETn;
  logic       baud_en;
  logic       baud_gen;
  logic       baud_force;
  logic       baud_run;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       fifo_clr;
  logic [5:0] lcr;
  logic       break_en;
  logic       stx;
  logic [4:0] fifo_count;
  logic       fifo_empty;
  logic       tx_empty;
  logic       overrun;

  int    n_checks = 0;
  int    n_errors = 0;
  int    gen_cnt  = 0;
  cell_t sb_q[$];
  vec_t  vecs[7];

  assign baud_en = baud_run ? baud_gen : baud_force;

  mfp_uart_tx_fifo #(.FIFO_DEPTH(DEPTH)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .baud_en    (baud_en),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .fifo_clr   (fifo_clr),
    .lcr        (lcr),
    .break_en   (break_en),
    .stx        (stx),
    .fifo_count (fifo_count),
    .fifo_empty (fifo_empty),
    .tx_empty   (tx_empty),
    .overrun    (overrun)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // 16x baud strobe: one cycle high every 4 clocks while running.
  initial begin
    baud_gen = 1'b0;
    forever begin
      @(negedge HCLK);
      if (baud_run) begin
        gen_cnt  = (gen_cnt + 1) % 4;
        baud_gen = (gen_cnt == 0);
      end else begin
        gen_cnt  = 0;
        baud_gen = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errors++;
      $display("FAIL %s: actual %0d required %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wr(input logic [7:0] d);
    @(negedge HCLK);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge HCLK);
    wr_en   = 1'b0;
  endtask

  task automatic push_frame(input logic [8:0] bits, input int nbits, input int stop_ticks);
    cell_t c;
    c.lvl = 1'b0; c.len = TICK_CLKS; sb_q.push_back(c);
    for (int i = 0; i < nbits; i++) begin
      c.lvl = bits[i]; c.len = TICK_CLKS; sb_q.push_back(c);
    end
    c.lvl = 1'b1; c.len = stop_ticks * 4; sb_q.push_back(c);
  endtask

  // Returns at the first negedge where stx is low (offset 0 of the start bit).
  task automatic wait_start(input string name, output bit ok);
    int n;
    n = 0;
    do begin
      @(negedge HCLK);
      n++;
    end while (stx !== 1'b0 && n < 1000);
    ok = (stx === 1'b0);
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s start: stx actual %b after %0d clocks, required start bit 0", name, stx, n);
    end
  endtask

  // Pop expected cells and sample each near its start and its end.
  task automatic check_frames(input string name);
    bit    ok;
    cell_t c;
    int    idx;
    wait_start(name, ok);
    if (!ok) begin
      sb_q.delete();
      return;
    end
    idx = 0;
    while (sb_q.size() > 0) begin
      c = sb_q.pop_front();
      @(negedge HCLK);
      chk($sformatf("%s cell%0d head", name, idx), 32'(stx), 32'(c.lvl));
      repeat (c.len - 3) @(negedge HCLK);
      chk($sformatf("%s cell%0d tail", name, idx), 32'(stx), 32'(c.lvl));
      repeat (2) @(negedge HCLK);
      idx++;
    end
  endtask

  initial begin
    bit ok;
    int n;

    vecs[0] = '{lcr: 6'b000011, data: 8'h55, exp_bits: 9'h055, nbits: 8, stop_ticks: 16}; // 8N1
    vecs[1] = '{lcr: 6'b011111, data: 8'h07, exp_bits: 9'h107, nbits: 9, stop_ticks: 32}; // 8E2
    vecs[2] = '{lcr: 6'b000100, data: 8'hFF, exp_bits: 9'h01F, nbits: 5, stop_ticks: 24}; // 5N1.5
    vecs[3] = '{lcr: 6'b001010, data: 8'h5A, exp_bits: 9'h0DA, nbits: 8, stop_ticks: 16}; // 7O1
    vecs[4] = '{lcr: 6'b101001, data: 8'h3C, exp_bits: 9'h07C, nbits: 7, stop_ticks: 16}; // 6 stick=1
    vecs[5] = '{lcr: 6'b111000, data: 8'h13, exp_bits: 9'h013, nbits: 6, stop_ticks: 16}; // 5 stick=0
    vecs[6] = '{lcr: 6'b000111, data: 8'hA3, exp_bits: 9'h0A3, nbits: 8, stop_ticks: 32}; // 8N2

    HRESETn    = 1'b0;
    wr_en      = 1'b0;
    wr_data    = 8'h00;
    fifo_clr   = 1'b0;
    lcr        = 6'b000011;
    break_en   = 1'b0;
    baud_run   = 1'b0;
    baud_force = 1'b0;

    #12;
    chk("reset stx", 32'(stx), 32'd1);
    chk("reset fifo_count", 32'(fifo_count), 32'd0);
    chk("reset fifo_empty", 32'(fifo_empty), 32'd1);
    chk("reset tx_empty", 32'(tx_empty), 32'd1);
    chk("reset overrun", 32'(overrun), 32'd0);
    @(negedge HCLK);
    HRESETn  = 1'b1;
    baud_run = 1'b1;

    // Frame formats
    for (int v = 0; v < 7; v++) begin
      lcr = vecs[v].lcr;
      push_frame(vecs[v].exp_bits, vecs[v].nbits, vecs[v].stop_ticks);
      wr(vecs[v].data);
      check_frames($sformatf("vec%0d", v));
      chk($sformatf("vec%0d tx_empty", v), 32'(tx_empty), 32'd1);
      chk($sformatf("vec%0d idle stx", v), 32'(stx), 32'd1);
      chk($sformatf("vec%0d fifo_count", v), 32'(fifo_count), 32'd0);
    end

    // Two bytes queued: second start bit follows the first stop with no gap
    lcr = 6'b000011;
    push_frame(9'h00F, 8, 16);
    push_frame(9'h0F0, 8, 16);
    wr(8'h0F);
    wr(8'hF0);
    check_frames("b2b");
    chk("b2b tx_empty", 32'(tx_empty), 32'd1);

    // Break mid-frame: line held low, frame timing unaffected
    wr(8'hFF);
    wait_start("break", ok);
    if (ok) begin
      repeat (100) @(negedge HCLK);
      break_en = 1'b1;
      #1 chk("break stx low", 32'(stx), 32'd0);
      repeat (200) @(negedge HCLK);
      chk("break stx held", 32'(stx), 32'd0);
      chk("break serializer busy", 32'(tx_empty), 32'd0);
      break_en = 1'b0;
      #1 chk("break released stx", 32'(stx), 32'd1);
      n = 0;
      do begin
        @(negedge HCLK);
        n++;
      end while (tx_empty !== 1'b1 && n < 2000);
      chk("break frame end time", 32'(n), 32'd340);
    end

    // Overflow, simultaneous push/pop while full, and flush
    @(negedge HCLK);
    baud_run = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge HCLK);
      wr_en   = 1'b1;
      wr_data = 8'(i);
    end
    @(negedge HCLK);
    wr_en = 1'b0;
    #1;
    chk("full count", 32'(fifo_count), 32'd16);
    chk("full overrun", 32'(overrun), 32'd0);
    chk("full fifo_empty", 32'(fifo_empty), 32'd0);
    @(negedge HCLK);
    wr_en      = 1'b1;
    wr_data    = 8'hAA;
    baud_force = 1'b1;
    @(negedge HCLK);
    wr_en      = 1'b0;
    baud_force = 1'b0;
    #1;
    chk("push+pop full count", 32'(fifo_count), 32'd16);
    chk("push+pop full overrun", 32'(overrun), 32'd0);
    chk("push+pop serializer busy", 32'(tx_empty), 32'd0);
    @(negedge HCLK);
    wr_en = 1'b1;
    @(negedge HCLK);
    wr_en = 1'b0;
    #1;
    chk("overflow count", 32'(fifo_count), 32'd16);
    chk("overflow overrun", 32'(overrun), 32'd1);
    @(negedge HCLK);
    fifo_clr = 1'b1;
    wr_en    = 1'b1;
    @(negedge HCLK);
    fifo_clr = 1'b0;
    wr_en    = 1'b0;
    #1;
    chk("clr count", 32'(fifo_count), 32'd0);
    chk("clr overrun", 32'(overrun), 32'd0);
    chk("clr fifo_empty", 32'(fifo_empty), 32'd1);
    chk("clr frame continues", 32'(tx_empty), 32'd0);
    @(negedge HCLK);
    chk("clr push discarded", 32'(fifo_count), 32'd0);
    baud_run = 1'b1;
    n = 0;
    do begin
      @(negedge HCLK);
      n++;
    end while (tx_empty !== 1'b1 && n < 2000);
    chk_range("clr frame length", n, 630, 645);
    chk("after clr stx", 32'(stx), 32'd1);

    // Asynchronous reset during DATA
    lcr = 6'b000011;
    wr(8'h00);
    wr(8'h00);
    wait_start("reset", ok);
    if (ok) begin
      repeat (100) @(negedge HCLK);
      chk("pre-reset stx data", 32'(stx), 32'd0);
      chk("pre-reset count", 32'(fifo_count), 32'd1);
      #2 HRESETn = 1'b0;
      #1;
      chk("async reset stx", 32'(stx), 32'd1);
      chk("async reset count", 32'(fifo_count), 32'd0);
      chk("async reset fifo_empty", 32'(fifo_empty), 32'd1);
      chk("async reset tx_empty", 32'(tx_empty), 32'd1);
      chk("async reset overrun", 32'(overrun), 32'd0);
      @(negedge HCLK);
      HRESETn = 1'b1;
      repeat (300) @(negedge HCLK);
      chk("post-reset stx idle", 32'(stx), 32'd1);
      chk("post-reset tx_empty", 32'(tx_empty), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
